integral_image: RTL and testbench

Streaming integral-image (summed-area table) generator that sits directly upstream of the adaptive-threshold stage. It consumes grayscale pixels in raster order and emits, per pixel, the sum of all pixels above and to the left of it, inclusive. The threshold stage then gets any window sum from four lookups. One frame is processed per `start` pulse, and throughput is one pixel per cycle when there is no backpressure.

---
 rtl/integral_pkg.sv | 22 ++
 rtl/line_buffer_ram.sv | 33 +++
 rtl/integral_image.sv | 161 ++++++++++++++++
 tb/tb_integral_image.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/integral_pkg.sv
// Shared constants and helpers for the streaming integral-image generator.
package integral_pkg;

   localparam int PIX_W_DEF = 8;
   localparam int SUM_W_DEF = 24;
   localparam int COORD_W   = 8;

   // Number of bits needed to hold the largest possible integral value,
   // i.e. WIDTH * HEIGHT * (2^PIX_W - 1).
   function automatic int min_sum_w(input int width, input int height, input int pix_w);
      longint unsigned max_val;
      int              bits;
      max_val = 64'(width) * 64'(height) * ((64'd1 << pix_w) - 64'd1);
      bits    = 0;
      while (max_val != 64'd0) begin
         bits++;
         max_val = max_val >> 1;
      end
      return bits;
   endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Holds the previous row's integral values, one word per column.
module line_buffer_ram #(
   parameter int DEPTH  = 256,
   parameter int DATA_W = 24,
   parameter int ADDR_W = 8
) (
   input  logic              clock,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   // Write port; contents need no reset because row 0 never reads them.
   always_ff @(posedge clock) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Registered read port.
   always_ff @(posedge clock) begin
      r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/integral_image.sv
// Streaming summed-area table generator: raster-order pixels in, one
// integral value per pixel out, one pixel per cycle without backpressure.
module integral_image
   import integral_pkg::*;
#(
   parameter int WIDTH  = 256,
   parameter int HEIGHT = 256,
   parameter int PIX_W  = PIX_W_DEF,
   parameter int SUM_W  = SUM_W_DEF
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PIX_W-1:0]   in_pixel,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [COORD_W-1:0] out_x,
   output logic [COORD_W-1:0] out_y,
   output logic [SUM_W-1:0]   out_sum,
   output logic               busy,
   output logic               done
);

   localparam int                 AW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - 1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(HEIGHT - 1);

   if (SUM_W < min_sum_w(WIDTH, HEIGHT, PIX_W)) begin : g_sum_w_check
      $error("integral_image: SUM_W too narrow for WIDTH*HEIGHT*max pixel");
   end
   if (WIDTH < 1 || WIDTH > 256 || HEIGHT < 1 || HEIGHT > 256) begin : g_dim_check
      $error("integral_image: WIDTH and HEIGHT must be within 1..256");
   end

   logic               r_busy;
   logic               r_last;
   logic               r_done;
   logic [COORD_W-1:0] r_x;
   logic [COORD_W-1:0] r_y;
   logic [SUM_W-1:0]   r_row_sum;
   logic [SUM_W-1:0]   r_fwd;
   logic               r_out_valid;
   logic [COORD_W-1:0] r_out_x;
   logic [COORD_W-1:0] r_out_y;
   logic [SUM_W-1:0]   r_out_sum;

   logic               w_in_ready;
   logic               w_accept;
   logic               w_x_wrap;
   logic               w_final_hs;
   logic [COORD_W-1:0] w_x_next;
   logic [SUM_W-1:0]   w_row_new;
   logic [SUM_W-1:0]   w_rd_data;
   logic [SUM_W-1:0]   w_above;
   logic [SUM_W-1:0]   w_sum;
   logic [AW-1:0]      w_waddr;
   logic [AW-1:0]      w_raddr;

   assign w_in_ready = r_busy && !r_last && (!r_out_valid || out_ready);
   assign w_accept   = in_valid && w_in_ready;
   assign w_x_wrap   = (r_x == X_LAST);
   assign w_x_next   = w_x_wrap ? '0 : r_x + COORD_W'(1);
   assign w_final_hs = r_busy && r_last && r_out_valid && out_ready;

   assign w_row_new  = ((r_x == '0) ? '0 : r_row_sum) + SUM_W'(in_pixel);
   // With a single column the read and write hit the same word, so the
   // value just written is taken from a register instead of the RAM.
   assign w_above    = (r_y == '0) ? '0 : ((WIDTH == 1) ? r_fwd : w_rd_data);
   assign w_sum      = w_row_new + w_above;

   // Reading the next column on accept keeps the RAM output aligned with
   // r_x, so back-to-back accepts need no stall.
   assign w_waddr    = r_x[AW-1:0];
   assign w_raddr    = w_accept ? w_x_next[AW-1:0] : r_x[AW-1:0];

   line_buffer_ram #(
      .DEPTH  (WIDTH),
      .DATA_W (SUM_W),
      .ADDR_W (AW)
   ) u_line_buffer (
      .clock   (clock),
      .i_we    (w_accept),
      .i_waddr (w_waddr),
      .i_wdata (w_sum),
      .i_raddr (w_raddr),
      .o_rdata (w_rd_data)
   );

   // Frame control: busy/last flags, raster counters and running row sum.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_busy    <= 1'b0;
         r_last    <= 1'b0;
         r_done    <= 1'b0;
         r_x       <= '0;
         r_y       <= '0;
         r_row_sum <= '0;
      end else begin
         r_done <= w_final_hs;
         if (start && !r_busy) begin
            r_busy    <= 1'b1;
            r_last    <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_row_sum <= '0;
         end else begin
            if (w_accept) begin
               r_row_sum <= w_row_new;
               r_x       <= w_x_next;
               if (w_x_wrap) begin
                  r_y <= r_y + COORD_W'(1);
                  if (r_y == Y_LAST) begin
                     r_last <= 1'b1;
                  end
               end
            end
            if (w_final_hs) begin
               r_busy <= 1'b0;
               r_last <= 1'b0;
            end
         end
      end
   end

   // Last written integral value, used as the "above" word when WIDTH is 1.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_fwd <= '0;
      end else if (w_accept) begin
         r_fwd <= w_sum;
      end
   end

   // Output register: load on accept, hold while stalled, drop after handshake.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_x     <= '0;
         r_out_y     <= '0;
         r_out_sum   <= '0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_out_x     <= r_x;
         r_out_y     <= r_y;
         r_out_sum   <= w_sum;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign out_x     = r_out_x;
   assign out_y     = r_out_y;
   assign out_sum   = r_out_sum;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_integral_image.sv
// Bench for integral_image: a 4x3 instance with a scoreboard, a 256x256
// all-255 instance and a single-column instance.
module tb_integral_image;
   import integral_pkg::*;

   localparam int SW = 4;
   localparam int SH = 3;
   localparam int SN = SW * SH;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int     n_cmp = 0;
   int     n_bad = 0;
   longint cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint expv);
      n_cmp++;
      if (act != expv) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   // ---------------- small 4x3 instance ----------------
   logic        s_reset = 1'b1, s_start = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b1;
   logic [7:0]  s_in_pixel = '0;
   logic        s_in_ready, s_out_valid, s_busy, s_done;
   logic [7:0]  s_out_x, s_out_y;
   logic [23:0] s_out_sum;

   integral_image #(.WIDTH(SW), .HEIGHT(SH), .PIX_W(8), .SUM_W(24)) u_small (
      .clock(clk), .reset(s_reset), .start(s_start), .in_valid(s_in_valid),
      .in_ready(s_in_ready), .in_pixel(s_in_pixel), .out_valid(s_out_valid),
      .out_ready(s_out_ready), .out_x(s_out_x), .out_y(s_out_y),
      .out_sum(s_out_sum), .busy(s_busy), .done(s_done)
   );

   typedef struct {
      int     x;
      int     y;
      longint sum;
   } exp_t;

   exp_t   sq[$];
   exp_t   e_s;
   int     frame_pix[SN];
   int     rdy_mode = 0;
   int     hs_cnt = 0, done_cnt = 0;
   longint first_cyc = 0, last_cyc = 0;
   bit     held = 0, prev_done = 0;
   logic [7:0]  hold_x, hold_y;
   logic [23:0] hold_sum;

   // Reference: plain double sum over the frame, inclusive of (x,y).
   function automatic longint ref_sum(input int x, input int y);
      longint s = 0;
      for (int j = 0; j <= y; j++)
         for (int i = 0; i <= x; i++)
            s += frame_pix[j*SW + i];
      return s;
   endfunction

   function automatic int pix_of(input int pat, input int k);
      case (pat)
         0:       return 1;
         1:       return k;          // x + 4y for a 4-wide frame
         2:       return k + 5;
         3:       return 2;
         default: return int'($urandom_range(0, 255));
      endcase
   endfunction

   initial begin
      forever begin
         @(posedge clk); #1;
         if (rdy_mode == 1) s_out_ready = 1'($urandom_range(0, 1));
         else if (rdy_mode == 0) s_out_ready = 1'b1;
      end
   end

   task automatic pulse_start;
      s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
   endtask

   task automatic feed(input int pat, input int k0, input int k_end, input int mid_k);
      for (int k = k0; k < k_end; k++) begin
         int waited;
         if (k == mid_k) begin
            s_in_valid = 1'b0;
            pulse_start();
            chk("busy_after_mid_start", s_busy, 1);
         end
         s_in_pixel   = 8'(pix_of(pat, k));
         frame_pix[k] = int'(s_in_pixel);
         s_in_valid   = 1'b1;
         waited = 0;
         @(negedge clk);
         while (!s_in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
         end
         if (!s_in_ready) begin
            chk("accept_timeout", s_in_ready, 1);
            break;
         end
         sq.push_back('{k % SW, k / SW, ref_sum(k % SW, k / SW)});
         @(posedge clk); #1;
      end
      s_in_valid = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (s_done) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("done_timeout", s_done, 1);
   endtask

   // Scoreboard monitor for the 4x3 instance.
   always @(negedge clk) begin
      if (held && !s_reset) begin
         chk("stall_valid_held", s_out_valid, 1);
         chk("stall_x_stable", s_out_x, hold_x);
         chk("stall_y_stable", s_out_y, hold_y);
         chk("stall_sum_stable", s_out_sum, hold_sum);
      end
      if (s_out_valid && s_out_ready) begin
         if (sq.size() == 0) begin
            chk("unexpected_output", sq.size(), 1);
         end else begin
            e_s = sq.pop_front();
            chk("out_x", s_out_x, e_s.x);
            chk("out_y", s_out_y, e_s.y);
            chk("out_sum", s_out_sum, e_s.sum);
            hs_cnt++;
            if (hs_cnt == 1) first_cyc = cyc;
            last_cyc = cyc;
         end
      end
      held     = s_out_valid && !s_out_ready;
      hold_x   = s_out_x;
      hold_y   = s_out_y;
      hold_sum = s_out_sum;
      if (s_done) begin
         done_cnt++;
         chk("done_after_last_hs", cyc, last_cyc + 1);
         chk("done_single_cycle", prev_done, 0);
      end
      prev_done = s_done;
   end

   task automatic small_seq;
      bit ok;
      // reset values
      @(posedge clk); @(negedge clk);
      chk("rst_in_ready", s_in_ready, 0);
      chk("rst_out_valid", s_out_valid, 0);
      chk("rst_out_x", s_out_x, 0);
      chk("rst_out_y", s_out_y, 0);
      chk("rst_out_sum", s_out_sum, 0);
      chk("rst_busy", s_busy, 0);
      chk("rst_done", s_done, 0);
      @(posedge clk); #1;
      s_reset = 1'b0;
      @(posedge clk); #1;
      chk("idle_in_ready", s_in_ready, 0);

      // all ones, always ready: 12 results in 12 consecutive cycles
      hs_cnt = 0; done_cnt = 0;
      pulse_start();
      chk("busy_after_start", s_busy, 1);
      feed(0, 0, SN, -1);
      wait_done(ok);
      @(posedge clk); #1;
      chk("t1_results", hs_cnt, SN);
      chk("t1_consecutive", last_cyc - first_cyc, SN - 1);
      chk("t1_done_pulses", done_cnt, 1);
      chk("t1_busy_low", s_busy, 0);

      // stall right after the first result
      hs_cnt = 0; done_cnt = 0;
      rdy_mode = 2; s_out_ready = 1'b0;
      pulse_start();
      s_in_pixel   = 8'(pix_of(2, 0));
      frame_pix[0] = int'(s_in_pixel);
      s_in_valid   = 1'b1;
      @(negedge clk);
      chk("stall_first_accept", s_in_ready, 1);
      sq.push_back('{0, 0, ref_sum(0, 0)});
      @(posedge clk); #1;
      s_in_pixel   = 8'(pix_of(2, 1));
      frame_pix[1] = int'(s_in_pixel);
      repeat (3) begin
         @(negedge clk);
         chk("stall_in_ready_low", s_in_ready, 0);
         chk("stall_out_valid", s_out_valid, 1);
         chk("stall_out_x", s_out_x, 0);
         chk("stall_out_y", s_out_y, 0);
         chk("stall_out_sum", s_out_sum, 5);
      end
      @(posedge clk); #1;
      rdy_mode = 0; s_out_ready = 1'b1;
      feed(2, 1, SN, -1);
      wait_done(ok);
      @(posedge clk); #1;
      chk("t2_results", hs_cnt, SN);

      // random backpressure, x+4y, start pulsed mid-frame
      hs_cnt = 0; done_cnt = 0;
      rdy_mode = 1;
      pulse_start();
      feed(1, 0, SN, 6);
      wait_done(ok);
      chk("t3_results", hs_cnt, SN);
      // start in the done cycle launches the next frame
      hs_cnt = 0;
      s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      chk("start_in_done_busy", s_busy, 1);
      feed(4, 0, SN, -1);
      wait_done(ok);
      @(posedge clk); #1;
      chk("t3b_results", hs_cnt, SN);
      chk("t3_done_pulses", done_cnt, 2);

      // reset mid-frame after 5 pixels, then an all-2 frame
      rdy_mode = 0; s_out_ready = 1'b1;
      pulse_start();
      feed(4, 0, 5, -1);
      s_reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      s_reset = 1'b0;
      sq.delete();
      chk("midrst_busy", s_busy, 0);
      chk("midrst_out_valid", s_out_valid, 0);
      chk("midrst_in_ready", s_in_ready, 0);
      hs_cnt = 0;
      pulse_start();
      feed(3, 0, SN, -1);
      wait_done(ok);
      @(posedge clk); #1;
      chk("t4_results", hs_cnt, SN);
      chk("sq_empty", sq.size(), 0);
   endtask

   // ---------------- large 256x256 instance ----------------
   logic        b_reset = 1'b1, b_start = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b1;
   logic [7:0]  b_in_pixel = 8'd255;
   logic        b_in_ready, b_out_valid, b_busy, b_done;
   logic [7:0]  b_out_x, b_out_y;
   logic [23:0] b_out_sum;
   int          bx = 0, by = 0, b_cnt = 0;

   integral_image #(.WIDTH(256), .HEIGHT(256), .PIX_W(8), .SUM_W(24)) u_big (
      .clock(clk), .reset(b_reset), .start(b_start), .in_valid(b_in_valid),
      .in_ready(b_in_ready), .in_pixel(b_in_pixel), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_x(b_out_x), .out_y(b_out_y),
      .out_sum(b_out_sum), .busy(b_busy), .done(b_done)
   );

   // All-255 frame: I(x,y) = 255*(x+1)*(y+1).
   always @(negedge clk) begin
      if (b_out_valid && b_out_ready) begin
         chk("big_x", b_out_x, bx);
         chk("big_y", b_out_y, by);
         chk("big_sum", b_out_sum, longint'(255 * (bx + 1) * (by + 1)));
         if (bx == 255 && by == 0)   chk("big_255_0", b_out_sum, 65280);
         if (bx == 0 && by == 255)   chk("big_0_255", b_out_sum, 65280);
         if (bx == 255 && by == 255) chk("big_final", b_out_sum, 24'hFF0000);
         b_cnt++;
         if (bx == 255) begin bx = 0; by++; end
         else bx++;
      end
   end

   task automatic big_seq;
      bit ok = 0;
      repeat (3) @(posedge clk);
      #1 b_reset = 1'b0;
      b_start = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0;
      b_in_valid = 1'b1;
      for (int i = 0; i < 70000; i++) begin
         @(negedge clk);
         if (b_done) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("big_done_timeout", b_done, 1);
      b_in_valid = 1'b0;
      chk("big_count", b_cnt, 65536);
   endtask

   // ---------------- single-column instance ----------------
   logic        o_reset = 1'b1, o_start = 1'b0, o_in_valid = 1'b0, o_out_ready = 1'b1;
   logic [7:0]  o_in_pixel = '0;
   logic        o_in_ready, o_out_valid, o_busy, o_done;
   logic [7:0]  o_out_x, o_out_y;
   logic [23:0] o_out_sum;
   int          o_pix[4];
   int          o_cnt = 0;
   longint      o_acc = 0;

   integral_image #(.WIDTH(1), .HEIGHT(4), .PIX_W(8), .SUM_W(24)) u_one (
      .clock(clk), .reset(o_reset), .start(o_start), .in_valid(o_in_valid),
      .in_ready(o_in_ready), .in_pixel(o_in_pixel), .out_valid(o_out_valid),
      .out_ready(o_out_ready), .out_x(o_out_x), .out_y(o_out_y),
      .out_sum(o_out_sum), .busy(o_busy), .done(o_done)
   );

   // One column: the integral is the running sum down the column.
   always @(negedge clk) begin
      if (o_out_valid && o_out_ready && o_cnt < 4) begin
         o_acc += o_pix[o_cnt];
         chk("col_x", o_out_x, 0);
         chk("col_y", o_out_y, o_cnt);
         chk("col_sum", o_out_sum, o_acc);
         o_cnt++;
      end
   end

   task automatic one_seq;
      bit ok = 0;
      for (int k = 0; k < 4; k++) o_pix[k] = int'($urandom_range(0, 255));
      repeat (2) @(posedge clk);
      #1 o_reset = 1'b0;
      o_start = 1'b1;
      @(posedge clk); #1;
      o_start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         int waited = 0;
         o_in_pixel = 8'(o_pix[k]);
         o_in_valid = 1'b1;
         @(negedge clk);
         while (!o_in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
         end
         if (!o_in_ready) begin
            chk("col_accept_timeout", o_in_ready, 1);
            break;
         end
         @(posedge clk); #1;
      end
      o_in_valid = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (o_done) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("col_done_timeout", o_done, 1);
      chk("col_count", o_cnt, 4);
   endtask

   initial begin
      fork
         small_seq();
         big_seq();
         one_seq();
      join
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
